// File: rtl/fetch_unit.sv
// fetch_unit: IF stage of the 5-stage MIPS pipeline.
// Holds the PC, drives instruction-memory address, selects next PC and owns
// the IF/ID pipeline register (stall, flush, bubble insertion, fault capture).
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [31:0] fetch_count,
  output logic        fault
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        pc_bad;
  logic        target_bad;

  // Next-PC candidates and fault conditions for the current fetch.
  always_comb begin
    pc_plus4    = pc_q + 32'd4;
    jump_target = {id_pc_plus4_q[31:28], jump_index, 2'b00};
    redirect    = jr | jump | branch_taken;
    // jr > jump > branch among the redirect sources
    if (jr) begin
      redirect_target = jr_target;
    end else if (jump) begin
      redirect_target = jump_target;
    end else begin
      redirect_target = branch_target;
    end
    pc_bad     = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= IMEM_DEPTH);
    target_bad = redirect && (redirect_target[1:0] != 2'b00);
  end

  // Next-state and IF/ID load logic; defaults hold every register.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_inst_d     = id_inst_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    fetch_count_d = fetch_count_q;
    fault_d       = fault_q;

    unique case (state_q)
      BOOT: begin
        id_inst_d     = '0;
        id_pc_plus4_d = '0;
        id_valid_d    = 1'b0;
        state_d       = RUN;
      end

      RUN: begin
        if (stall) begin
          // Hold everything; redirects are re-presented by branch logic.
        end else if (pc_bad || target_bad) begin
          // Faulting fetch is dropped and a bad target never reaches pc.
          id_inst_d     = '0;
          id_pc_plus4_d = '0;
          id_valid_d    = 1'b0;
          fault_d       = 1'b1;
          state_d       = FAULT;
        end else if (redirect) begin
          pc_d          = redirect_target;
          id_inst_d     = '0;
          id_pc_plus4_d = '0;
          id_valid_d    = 1'b0;
        end else begin
          pc_d          = pc_plus4;
          id_inst_d     = imem_data;
          id_pc_plus4_d = pc_plus4;
          id_valid_d    = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end

      FAULT: begin
        id_inst_d     = '0;
        id_pc_plus4_d = '0;
        id_valid_d    = 1'b0;
        fault_d       = 1'b1;
      end

      default: begin
        state_d = FAULT;
        fault_d = 1'b1;
      end
    endcase
  end

  // State, PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      id_inst_q     <= '0;
      id_pc_plus4_q <= '0;
      id_valid_q    <= 1'b0;
      fetch_count_q <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_inst_q     <= id_inst_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      fetch_count_q <= fetch_count_d;
      fault_q       <= fault_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign id_inst     = id_inst_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;
  assign fetch_count = fetch_count_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset/boot, sequential fetch, stall, jump,
// redirect priority, mid-operation reset, misaligned-target and range faults.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [31:0] fetch_count;
  logic        fault;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .pc            (pc),
    .id_inst       (id_inst),
    .id_pc_plus4   (id_pc_plus4),
    .id_valid      (id_valid),
    .fetch_count   (fetch_count),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word 0 is 0x820, word i is 0x1000_0000+i, 0 outside.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [29:0] w;
    w = a[31:2];
    if (w >= 30'd32) return 32'h0;
    if (w == 30'd0) return 32'h0000_0820;
    return 32'h1000_0000 | {2'b00, w};
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                         input logic [31:0] e_pc4, input logic e_valid,
                         input logic [31:0] e_cnt, input logic e_fault);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".imem_addr"}, imem_addr, e_pc);
    chk({tag, ".id_inst"}, id_inst, e_inst);
    chk({tag, ".id_pc_plus4"}, id_pc_plus4, e_pc4);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, e_valid});
    chk({tag, ".fetch_count"}, fetch_count, e_cnt);
    chk({tag, ".fault"}, {31'd0, fault}, {31'd0, e_fault});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_index = '0; jr = 1'b0; jr_target = '0;

    // Reset and boot
    step(); step();
    chk_all("reset", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    step();
    chk_all("boot", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    step();
    chk_all("first", 32'd4, 32'h0000_0820, 32'd4, 1'b1, 32'd1, 1'b0);
    step();
    chk_all("seq8", 32'd8, 32'h1000_0001, 32'd8, 1'b1, 32'd2, 1'b0);
    step();
    chk_all("seq12", 32'd12, 32'h1000_0002, 32'd12, 1'b1, 32'd3, 1'b0);

    // Stall three cycles, with a branch present that must be ignored
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd64;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("stall", 32'd12, 32'h1000_0002, 32'd12, 1'b1, 32'd3, 1'b0);
    end
    stall = 1'b0; branch_taken = 1'b0;
    step();
    chk_all("resume", 32'd16, 32'h1000_0003, 32'd16, 1'b1, 32'd4, 1'b0);
    step();
    chk_all("seq20", 32'd20, 32'h1000_0004, 32'd20, 1'b1, 32'd5, 1'b0);
    step();
    chk_all("seq24", 32'd24, 32'h1000_0005, 32'd24, 1'b1, 32'd6, 1'b0);

    // Jump back to 12 using id_pc_plus4=24
    jump = 1'b1; jump_index = 26'd3;
    step();
    chk_all("jump", 32'd12, 32'd0, 32'd0, 1'b0, 32'd6, 1'b0);
    jump = 1'b0;
    step();
    chk_all("jump_tgt", 32'd16, 32'h1000_0003, 32'd16, 1'b1, 32'd7, 1'b0);

    // Priority: stall beats all redirects, then jr wins
    jr = 1'b1; jr_target = 32'd40; jump = 1'b1; jump_index = 26'd3;
    branch_taken = 1'b1; branch_target = 32'd24; stall = 1'b1;
    step();
    chk_all("prio_stall", 32'd16, 32'h1000_0003, 32'd16, 1'b1, 32'd7, 1'b0);
    stall = 1'b0;
    step();
    chk_all("prio_jr", 32'd40, 32'd0, 32'd0, 1'b0, 32'd7, 1'b0);
    jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    step();
    chk_all("jr_tgt", 32'd44, 32'h1000_000A, 32'd44, 1'b1, 32'd8, 1'b0);

    // Branch alone redirects
    branch_taken = 1'b1; branch_target = 32'd8;
    step();
    chk_all("branch", 32'd8, 32'd0, 32'd0, 1'b0, 32'd8, 1'b0);
    branch_taken = 1'b0;
    step();
    chk_all("br_tgt", 32'd12, 32'h1000_0002, 32'd12, 1'b1, 32'd9, 1'b0);

    // Reset mid-stall with branch pending
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd8; reset = 1'b1;
    step();
    chk_all("rst_mid", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    step();
    chk_all("boot2", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    step();
    chk_all("first2", 32'd4, 32'h0000_0820, 32'd4, 1'b1, 32'd1, 1'b0);

    // Misaligned branch target faults; fault is sticky and ignores inputs
    branch_taken = 1'b1; branch_target = 32'd26;
    step();
    chk_all("mis_br", 32'd4, 32'd0, 32'd0, 1'b0, 32'd1, 1'b1);
    branch_taken = 1'b0; jr = 1'b1; jr_target = 32'd0;
    step();
    chk_all("flt_jr", 32'd4, 32'd0, 32'd0, 1'b0, 32'd1, 1'b1);
    jr = 1'b0; stall = 1'b1;
    step();
    chk_all("flt_stall", 32'd4, 32'd0, 32'd0, 1'b0, 32'd1, 1'b1);
    stall = 1'b0;
    step();
    chk_all("flt_seq", 32'd4, 32'd0, 32'd0, 1'b0, 32'd1, 1'b1);

    // Reset clears fault
    reset = 1'b1;
    step();
    chk_all("rst_flt", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;

    // Sequential run to the end of memory, then out-of-range fault at 128
    step();
    for (int i = 0; i < 32; i++) step();
    chk_all("last", 32'd128, 32'h1000_001F, 32'd128, 1'b1, 32'd32, 1'b0);
    step();
    chk_all("range", 32'd128, 32'd0, 32'd0, 1'b0, 32'd32, 1'b1);
    step();
    chk_all("range2", 32'd128, 32'd0, 32'd0, 1'b0, 32'd32, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
